// File: rtl/saxil_read_regbank.sv
// ---------------------------------------------------------------------------
// saxil_read_regbank
//
// AXI4-Lite slave read channel in front of a local bank of DEPTH registers.
// User logic writes the registers through a simple strobe/index/data side
// port; the AXI side reads them with up to RESP_DEPTH responses outstanding.
// Misaligned or out-of-range addresses return SLVERR with zero data, and
// every SLVERR issued is counted in a saturating 16-bit counter.
//
// Optional feature (compile-time macro SAXIL_READ_PROT_CHECK_EN):
//   when defined, reads that are unprivileged (arprot[0]=0) or non-secure
//   (arprot[1]=1) return SLVERR regardless of address.
//
// Ports:
//   saxil_read_regbank_clk   clock, rising edge
//   saxil_read_regbank_rst   synchronous reset, active-high
//   saxil_read_ar*           AR channel (valid/ready/addr/prot)
//   saxil_read_r*            R channel (valid/ready/data/resp)
//   reg_wr_en/idx/data       register write side port (idx >= DEPTH ignored)
//   rd_err_cnt               saturating count of SLVERR responses issued
// ---------------------------------------------------------------------------
module saxil_read_regbank #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                RESP_DEPTH = 2
) (
    input  logic              saxil_read_regbank_clk,
    input  logic              saxil_read_regbank_rst,
    input  logic              saxil_read_arvalid,
    output logic              saxil_read_arready,
    input  logic [ADDR_W-1:0] saxil_read_araddr,
    input  logic [2:0]        saxil_read_arprot,
    output logic              saxil_read_rvalid,
    input  logic              saxil_read_rready,
    output logic [DATA_W-1:0] saxil_read_rdata,
    output logic [1:0]        saxil_read_rresp,
    input  logic              reg_wr_en,
    input  logic [7:0]        reg_wr_idx,
    input  logic [DATA_W-1:0] reg_wr_data,
    output logic [15:0]       rd_err_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(DEPTH * BYTES);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RESP_DEPTH - 1);

    logic clk;
    logic srst;
    assign clk  = saxil_read_regbank_clk;
    assign srst = saxil_read_regbank_rst;

    // -----------------------------------------------------------------------
    // Register bank: one register per generate slot, flattened into a packed
    // bank so the read mux can index it.
    // -----------------------------------------------------------------------
    logic [DEPTH-1:0][DATA_W-1:0] reg_bank;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic [DATA_W-1:0] val_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    val_reg <= '0;
                end else if (reg_wr_en && (reg_wr_idx == 8'(gi))) begin
                    val_reg <= reg_wr_data;
                end
            end

            assign reg_bank[gi] = val_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Queue state and handshakes
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] q_data_reg [RESP_DEPTH];
    logic [1:0]        q_resp_reg [RESP_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [15:0]       err_cnt_reg, err_cnt_next;

    logic ar_hs;
    logic r_hs;

    // arready depends only on the registered occupancy, so a pop in the same
    // cycle never opens a slot for a push when the queue is full.
    assign saxil_read_arready = (count_reg < CNT_W'(RESP_DEPTH));
    assign saxil_read_rvalid  = (count_reg != '0);
    assign ar_hs = saxil_read_arvalid & saxil_read_arready;
    assign r_hs  = saxil_read_rvalid & saxil_read_rready;

    // -----------------------------------------------------------------------
    // Address decode. The subtraction wraps, so addresses below BASE_ADDR
    // land far above SPAN and fall out as range errors.
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] off;
    logic              misaligned;
    logic              out_of_range;
    logic              prot_err;
    logic              rd_err;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

    assign off          = saxil_read_araddr - BASE_ADDR;
    assign misaligned   = |saxil_read_araddr[OFS-1:0];
    assign out_of_range = (off >= SPAN);
    assign rd_idx       = off[OFS +: IDX_W];

`ifdef SAXIL_READ_PROT_CHECK_EN
    assign prot_err = ~saxil_read_arprot[0] | saxil_read_arprot[1];
    logic unused_prot;
    assign unused_prot = saxil_read_arprot[2];
`else
    assign prot_err = 1'b0;
    logic unused_prot;
    assign unused_prot = ^saxil_read_arprot;
`endif

    assign rd_err = misaligned | out_of_range | prot_err;

    // The bank is sampled before this edge's user write lands, which gives
    // read-before-write on a same-index collision.
    always_comb begin
        rd_data = '0;
        if (!rd_err) begin
            rd_data = reg_bank[rd_idx];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic for pointers, occupancy and error counter
    // -----------------------------------------------------------------------
    always_comb begin
        rd_ptr_next  = rd_ptr_reg;
        wr_ptr_next  = wr_ptr_reg;
        count_next   = count_reg;
        err_cnt_next = err_cnt_reg;

        if (ar_hs) begin
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (r_hs) begin
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
        end

        case ({ar_hs, r_hs})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (ar_hs && rd_err && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_next = err_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            err_cnt_reg <= '0;
        end else begin
            rd_ptr_reg  <= rd_ptr_next;
            wr_ptr_reg  <= wr_ptr_next;
            count_reg   <= count_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    // Queue payload needs no reset: it is only visible while count != 0.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            q_data_reg[wr_ptr_reg] <= rd_data;
            q_resp_reg[wr_ptr_reg] <= rd_err ? 2'b10 : 2'b00;
        end
    end

    // -----------------------------------------------------------------------
    // R channel outputs: head of queue, forced to zero when empty
    // -----------------------------------------------------------------------
    always_comb begin
        saxil_read_rdata = '0;
        saxil_read_rresp = 2'b00;
        if (saxil_read_rvalid) begin
            saxil_read_rdata = q_data_reg[rd_ptr_reg];
            saxil_read_rresp = q_resp_reg[rd_ptr_reg];
        end
    end

    assign rd_err_cnt = err_cnt_reg;

endmodule

// File: doc/saxil_read_regbank.md
Name: saxil_read_regbank

Overview:
Parametrised AXI4-Lite slave read channel fronting a local register bank of DEPTH words, written by user logic through a simple side port. Supports pipelined reads through a response queue of RESP_DEPTH entries, returns SLVERR for misaligned or out-of-range addresses, and counts error responses. Sits behind the interconnect as the read half of a control/status block. Successor to the single-outstanding saxil_read_top.

Parameters:
ADDR_W, 32, AXI address width.
DATA_W, 32, data width; 32 or 64 only. Byte-offset bits OFS = log2(DATA_W/8).
DEPTH, 16, number of registers; 1..256.
BASE_ADDR, 0, byte address of register 0; aligned to DATA_W/8.
RESP_DEPTH, 2, response queue entries; 1..8.

Ports:
saxil_read_regbank_clk  in  1  clock, all logic on rising edge
saxil_read_regbank_rst  in  1  synchronous reset, active-high
saxil_read_arvalid  in  1  read address valid
saxil_read_arready  out  1  read address ready
saxil_read_araddr  in  ADDR_W  read byte address
saxil_read_arprot  in  3  protection attributes
saxil_read_rvalid  out  1  read data valid
saxil_read_rready  in  1  read data ready
saxil_read_rdata  out  DATA_W  read data
saxil_read_rresp  out  2  00 OKAY, 10 SLVERR
reg_wr_en  in  1  user register write strobe
reg_wr_idx  in  8  register index; ignored if >= DEPTH
reg_wr_data  in  DATA_W  register write data
rd_err_cnt  out  16  saturating count of SLVERR responses issued

Behaviour:
- Reset (synchronous, rst=1 at an edge): queue count=0, rvalid=0, rdata=0, rresp=00, rd_err_cnt=0, all registers=0. Reset mid-operation flushes queued/in-flight responses with no R beat. A reg_wr_en in the reset cycle is ignored.
- arready = (count < RESP_DEPTH), from registered state only; no combinational path from any input.
- AR handshake = arvalid & arready at an edge. At that edge, decode and look up the register, then push {data,resp} into the queue.
- Decode in ADDR_W-bit unsigned arithmetic: off = araddr - BASE_ADDR (wraps). Error if araddr[OFS-1:0] != 0, or off >= DEPTH*(DATA_W/8). Addresses below BASE_ADDR wrap to large values and are therefore errors.
- Response content: on error, data=0 and resp=10. Otherwise data=reg[off>>OFS] and resp=00.
- Latency: handshake at edge N gives rvalid=1 from just after edge N, i.e. one cycle of minimum latency. Back-to-back handshakes are accepted every cycle while the queue is not full.
- rvalid = (count != 0). rdata/rresp present the queue head and read 0/00 whenever rvalid=0. Head entry is stable while rvalid & !rready.
- R handshake = rvalid & rready at an edge; this pops the head.
- Push and pop in the same edge: count is unchanged and order is preserved. When full, arready=0 even if a pop occurs that edge; no same-cycle refill.
- Responses are returned strictly in AR order.
- Register write: reg_wr_en & reg_wr_idx<DEPTH updates the register at that edge. A read handshaking at the same edge to the same index captures the old value (read-before-write).
- rd_err_cnt increments by 1 at each edge where a response with resp=10 is pushed, and saturates at 0xFFFF.
- arprot is ignored unless the optional feature is enabled.

Optional Feature:
Macro SAXIL_READ_PROT_CHECK_EN.
- Defined: a handshake with arprot[0]=0 (unprivileged) or arprot[1]=1 (non-secure) returns SLVERR with data=0 regardless of address, and counts in rd_err_cnt.
- Not defined: arprot is unused and has no effect on responses or the counter.

Test Plan:
1. Reset checks: rst=1 for 2 cycles, then release -> arready=1, rvalid=0, rdata=0, rresp=00, rd_err_cnt=0.
2. Single read: reg_wr reg[3]=0xDEADBEEF; AR 0x0000000C with rready=1 -> rvalid next cycle, rdata=0xDEADBEEF, rresp=00.
3. Back-pressure and ordering: rready=0, AR to 0x0, 0x4, 0x8 (regs 0x11, 0x22, 0x33), RESP_DEPTH=2 -> arready=0 after the 2nd handshake. Raise rready -> data 0x11, 0x22, 0x33 in order, with the 3rd AR accepted only after the first pop.
4. Errors: AR to 0x00000002, to 0x40 (DEPTH=16), and to 0xFFFFFFFC -> each returns rdata=0, rresp=10; rd_err_cnt=3.
5. Collision and flush: reg_wr reg[1]=0xA5 on the same edge as AR 0x4, where the old value is 0x5A -> rdata=0x5A; a subsequent read returns 0xA5. Then assert rst with 2 queued responses -> rvalid=0 the next cycle and no R beat is issued.
6. With SAXIL_READ_PROT_CHECK_EN defined: AR 0x0 with arprot=3'b000 -> rresp=10, rdata=0; arprot=3'b001 -> rresp=00. Without the macro, arprot=3'b000 -> rresp=00.
